status_value_dispatch: RTL

STATUS_VALUE_DISPATCH -- requirements
Module: status_value_dispatch

---
 rtl/status_value_dispatch.sv | 116 +++++++++++
 1 files changed

// File: rtl/status_value_dispatch.sv
// Pulls entries from an upstream status vector into a 2-entry FIFO and dispatches
// them downstream under valid/ready, with a flush mode that drains the vector.
module status_value_dispatch #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 vec_valid_i,
  input  logic [WIDTH-1:0]     vec_value_i,
  output logic                 vec_pull_o,
  output logic                 out_valid_o,
  output logic [WIDTH-1:0]     out_value_o,
  input  logic                 out_ready_i,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic [1:0]           level_o,
  output logic [CNT_WIDTH-1:0] disp_cnt_o
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       mem_q [2];
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;
  logic [1:0]             level_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   flush_done_q;
  logic                   push;
  logic                   pop;

  // Everything below is decoded from registered state; out_ready_i only feeds pop.
  assign out_valid_o  = (state_q == ST_RUN) && (level_q != 2'd0);
  assign out_value_o  = mem_q[rd_ptr_q];
  assign level_o      = level_q;
  assign disp_cnt_o   = cnt_q;
  assign flush_done_o = flush_done_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    vec_pull_o = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (!rst_i) begin
      if (state_q == ST_RUN) begin
        vec_pull_o = vec_valid_i & ~flush_i & (level_q != 2'd2);
        push       = vec_pull_o;
        pop        = out_valid_o & out_ready_i;
      end else begin
        // Draining: accept whatever the vector offers and drop it.
        vec_pull_o = vec_valid_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      level_q      <= 2'd0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      // NOTE: the two buffer words are reset too because out_value_o must read 0
      // during reset; a deeper memory would normally be left unreset.
      mem_q        <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values of the others regardless of statement order.
      flush_done_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (flush_i) begin
            // Any push or pop decoded this cycle is dropped with the contents.
            state_q  <= ST_FLUSH;
            level_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
          end else begin
            if (push) begin
              mem_q[wr_ptr_q] <= vec_value_i;
              wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
              rd_ptr_q <= ~rd_ptr_q;
              if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + 1'b1;
            end
            unique case ({push, pop})
              2'b10:   level_q <= level_q + 2'd1;
              2'b01:   level_q <= level_q - 2'd1;
              default: level_q <= level_q;
            endcase
          end
        end
        ST_FLUSH: begin
          if (!vec_valid_i && !flush_i) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  a_hold_under_backpressure : assert property (
    @(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_value_o))
  );

endmodule
